alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the RISC-V pipeline EX stage. It extends the single-cycle integer ALU with a configurable data width, signed and unsigned compare, and XOR. It adds iterative unsigned multiply, divide and remainder. Operands are accepted and results delivered over valid/ready handshakes, so the hazard unit can stall the pipeline while an iterative operation runs.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mc_iter.sv | 40 ++++
 rtl/alu_mc.sv | 88 ++++++++
 tb/tb_alu_mc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and iterative-op classifier shared by alu_mc
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1100;
  localparam logic [3:0] ALU_REMU = 4'b1101;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  function automatic logic is_iterative(input logic [3:0] op);
    return op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU;
  endfunction
endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shift-add multiplier and restoring divider, one step per enabled cycle
module alu_mc_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             start,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);
  logic [3:0]       op_q;
  logic [WIDTH-1:0] x, y, acc, x_n, y_n, acc_n;
  logic [WIDTH:0]   r_sh, diff;
  logic             is_mul;
  always_comb begin
    is_mul = op_q == ALU_MUL;
    r_sh   = {acc, x[WIDTH-1]};
    diff   = r_sh - {1'b0, y};
    acc_n  = is_mul ? acc + (y[0] ? x : '0) : diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    x_n    = is_mul ? x << 1 : {x[WIDTH-2:0], ~diff[WIDTH]};
    y_n    = is_mul ? y >> 1 : y;
    out    = (is_mul || op_q == ALU_REMU) ? acc_n : x_n;
  end
  always_ff @(posedge clk) begin
    if (start) begin
      op_q <= op;
      x    <= a;
      y    <= b;
      acc  <= '0;
    end else if (step) begin
      x    <= x_n;
      y    <= y_n;
      acc  <= acc_n;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU with valid/ready handshakes and iterative mul/div
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluoperation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] simple, iter_out, res_n;
  logic             ld, start;
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign busy      = state == ST_BUSY;
  assign start     = in_ready && in_valid && is_iterative(aluoperation);
  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .start(start),
    .step (busy),
    .op   (aluoperation),
    .a    (a),
    .b    (b),
    .out  (iter_out)
  );
  always_comb begin
    case (aluoperation)
      ALU_ADD:  simple = a + b;
      ALU_SUB:  simple = a - b;
      ALU_AND:  simple = a & b;
      ALU_OR:   simple = a | b;
      ALU_XOR:  simple = a ^ b;
      ALU_SLT:  simple = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: simple = {{(WIDTH-1){1'b0}}, a < b};
      default:  simple = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ld      = 1'b0;
    res_n   = simple;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_n = is_iterative(aluoperation) ? ST_BUSY : ST_DONE;
          cnt_n   = is_iterative(aluoperation) ? CW'(WIDTH) : cnt;
          ld      = !is_iterative(aluoperation);
        end
      end
      ST_BUSY: begin
        cnt_n   = cnt - 1'b1;
        ld      = cnt == CW'(1);
        res_n   = iter_out;
        state_n = ld ? ST_DONE : ST_BUSY;
      end
      ST_DONE: state_n = out_ready ? ST_IDLE : ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ld) begin
        result <= res_n;
        zero   <= res_n == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven and sequence checks of alu_mc handshakes, results and latency
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [31:0] a, b, result;
  logic [3:0]  aluoperation;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t v[19];
  alu_mc #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .aluoperation(aluoperation),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic z, output int lat,
                        output int bcnt, output int rcnt);
    aluoperation = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    bcnt = 0;
    rcnt = 0;
    while (!out_valid && lat < 100) begin
      bcnt += int'(busy);
      rcnt += int'(in_ready);
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    z = zero;
    check("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
  endtask
  initial begin
    logic [31:0] r;
    logic        z;
    int          lat, bcnt, rcnt, pulses;
    v[0]  = '{4'b0000, 32'd5,        32'd7,        32'd12,         1};
    v[1]  = '{4'b0001, 32'd9,        32'd9,        32'd0,          1};
    v[2]  = '{4'b0101, 32'hFFFFFFFF, 32'd1,        32'd1,          1};
    v[3]  = '{4'b0110, 32'hFFFFFFFF, 32'd1,        32'd0,          1};
    v[4]  = '{4'b0100, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0,   1};
    v[5]  = '{4'b0010, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000,   1};
    v[6]  = '{4'b0011, 32'hF0F0F0F0, 32'h0000FFFF, 32'hF0F0FFFF,   1};
    v[7]  = '{4'b0101, 32'd1,        32'hFFFFFFFF, 32'd0,          1};
    v[8]  = '{4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,          1};
    v[9]  = '{4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF,   1};
    v[10] = '{4'b0111, 32'd3,        32'd4,        32'd0,          1};
    v[11] = '{4'b1000, 32'h00010000, 32'h00010001, 32'h00010000,  33};
    v[12] = '{4'b1100, 32'd100,      32'd7,        32'd14,        33};
    v[13] = '{4'b1101, 32'd100,      32'd7,        32'd2,         33};
    v[14] = '{4'b1100, 32'd5,        32'd0,        32'hFFFFFFFF,  33};
    v[15] = '{4'b1101, 32'd5,        32'd0,        32'd5,         33};
    v[16] = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,         33};
    v[17] = '{4'b1100, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF,  33};
    v[18] = '{4'b1101, 32'hFFFFFFFF, 32'd16,       32'd15,        33};
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    aluoperation = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", {31'b0, zero}, 32'd1);
    for (int i = 0; i < 19; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r, z, lat, bcnt, rcnt);
      check($sformatf("v%0d_result", i), r, v[i].exp);
      check($sformatf("v%0d_zero", i), {31'b0, z}, {31'b0, v[i].exp == 32'd0});
      check($sformatf("v%0d_latency", i), lat, v[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bcnt, v[i].lat == 1 ? 0 : 32);
      check($sformatf("v%0d_in_ready_while_busy", i), rcnt, 0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_back_to_idle", i), {30'b0, out_valid, in_ready}, 32'd1);
      check($sformatf("v%0d_result_held_idle", i), result, v[i].exp);
    end
    out_ready = 1'b0;
    run_op(4'b0000, 32'd3, 32'd4, r, z, lat, bcnt, rcnt);
    check("bp_first_result", r, 32'd7);
    aluoperation = 4'b0001;
    a = 32'd10;
    b = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
      check("bp_result_held", result, 32'd7);
      check("bp_zero_held", {31'b0, zero}, 32'd0);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", {30'b0, out_valid, in_ready}, 32'd1);
    check("bp_release_result", result, 32'd7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_valid", {31'b0, out_valid}, 32'd1);
    check("bp_second_result", result, 32'd9);
    @(posedge clk);
    #1;
    aluoperation = 4'b1000;
    a = 32'd1234;
    b = 32'd5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_busy_low", {31'b0, busy}, 32'd0);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_zero", {31'b0, zero}, 32'd1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      pulses += int'(out_valid) + int'(busy);
    end
    check("rst_no_stale_activity", pulses, 0);
    run_op(4'b0000, 32'd1, 32'd1, r, z, lat, bcnt, rcnt);
    check("post_rst_add_result", r, 32'd2);
    check("post_rst_add_latency", lat, 1);
    @(posedge clk);
    #1;
    run_op(4'b1111, 32'd55, 32'd66, r, z, lat, bcnt, rcnt);
    check("bad_op_result", r, 32'd0);
    check("bad_op_zero", {31'b0, z}, 32'd1);
    check("bad_op_latency", lat, 1);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
